// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - byte-stream configuration loader with checksum-gated apply
//
// Assembles NBYTES payload bytes into a shadow image. A trailing checksum byte
// must bring the 8-bit additive sum to zero. Only then is the image copied to
// prog, together with a single-cycle prog_en strobe.
//
// Ports:
//   clb_clk    fabric clock, rising edge
//   rst_n      synchronous active-low reset
//   start      begin a load (sampled in IDLE only)
//   abort      cancel a load (sampled in LOAD/CSUM only, beats a handshake)
//   cfg_data   stream byte, accepted when cfg_valid && cfg_ready
//   cfg_valid  cfg_data qualifier
//   cfg_ready  registered; high in LOAD and CSUM
//   prog       applied configuration image, registered
//   prog_en    one-cycle program strobe
//   busy       high whenever the FSM is not in IDLE
//   done       sticky: last load applied
//   error      sticky: last load failed its checksum
//   byte_count payload bytes accepted in the current load (saturates at NBYTES)
module cfg_loader #(
  parameter  int PROG_WIDTH = 4480,
  localparam int NBYTES     = PROG_WIDTH / 8,
  localparam int CNT_W      = $clog2(NBYTES + 1)
) (
  input  logic                  clb_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [PROG_WIDTH-1:0] prog,
  output logic                  prog_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      byte_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CSUM  = 3'd2,
    CHECK = 3'd3,
    APPLY = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(NBYTES);

  state_t                  state;
  state_t                  next_state;
  logic                    accept;
  logic [PROG_WIDTH-1:0]   shadow;
  logic [7:0]              acc;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        // abort is checked first so a simultaneous handshake is dropped
        if (abort) begin
          next_state = IDLE;
        end else if (cfg_valid && cfg_ready) begin
          accept = 1'b1;
          if (byte_count == LAST_BYTE) next_state = CSUM;
        end
      end
      CSUM: begin
        if (abort) begin
          next_state = IDLE;
        end else if (cfg_valid && cfg_ready) begin
          accept     = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        next_state = (acc == 8'd0) ? APPLY : IDLE;
      end
      APPLY: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clb_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prog       <= '0;
      prog_en    <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
      shadow     <= '0;
      acc        <= 8'd0;
    end else begin
      state     <= next_state;
      // Registered from next_state so they track the state they describe
      cfg_ready <= (next_state == LOAD) || (next_state == CSUM);
      busy      <= (next_state != IDLE);
      prog_en   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            byte_count <= '0;
            acc        <= 8'd0;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            shadow <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
          end else if (accept) begin
            shadow <= {shadow[PROG_WIDTH-9:0], cfg_data};
            acc    <= acc + cfg_data;
            if (byte_count != FULL) byte_count <= byte_count + 1'b1;
          end
        end
        CSUM: begin
          if (abort) begin
            shadow <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
          end else if (accept) begin
            acc <= acc + cfg_data;
          end
        end
        CHECK: begin
          if (acc == 8'd0) begin
            prog    <= shadow;
            prog_en <= 1'b1;
            done    <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - self-checking bench for cfg_loader
module tb_cfg_loader;

  localparam int PW = 4480;
  localparam int NB = PW / 8;
  localparam int CW = $clog2(NB + 1);

  logic          clb_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] prog;
  logic          prog_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] byte_count;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  bit prev_en = 1'b0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] img_a5;

  cfg_loader #(.PROG_WIDTH(PW)) dut (
    .clb_clk(clb_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .prog(prog), .prog_en(prog_en), .busy(busy), .done(done),
    .error(error), .byte_count(byte_count)
  );

  always #5 clb_clk = ~clb_clk;

  function automatic logic [7:0] pbyte(input int pat, input int i);
    return (pat == 0) ? 8'(i) : 8'hA5;
  endfunction

  function automatic logic [PW-1:0] make_img(input int pat);
    logic [PW-1:0] img = '0;
    for (int i = 0; i < NB; i++) img = {img[PW-9:0], pbyte(pat, i)};
    return img;
  endfunction

  // Scoreboard: each prog_en strobe must match the oldest expected image
  always @(negedge clb_clk) begin
    if (prog_en) begin
      pulse_cnt++;
      total++;
      if (prev_en) begin
        bad++;
        $display("FAIL prog_en_width: actual=high two cycles required=one cycle");
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_prog_en: actual=strobe required=none");
      end else begin
        logic [PW-1:0] exp_img;
        exp_img = sb.pop_front();
        if (prog !== exp_img) begin
          int k;
          bad++;
          for (k = 0; k < NB; k++)
            if (prog[PW-1-8*k -: 8] !== exp_img[PW-1-8*k -: 8]) break;
          $display("FAIL prog_image: byte %0d actual=%02h required=%02h",
                   k, prog[PW-1-8*k -: 8], exp_img[PW-1-8*k -: 8]);
        end
      end
    end
    prev_en = prog_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Offer one byte; returns 1 ns after the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(negedge clb_clk);
    end
    @(negedge clb_clk);
    cfg_data  = b;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 100) begin
      @(negedge clb_clk);
      n++;
    end
    if (!cfg_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: actual=cfg_ready low required=high");
    end
    @(posedge clb_clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clb_clk);
    start = 1'b1;
    @(posedge clb_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input int pat, input bit gaps, input logic [7:0] csum);
    pulse_start();
    for (int i = 0; i < NB; i++) send_byte(pbyte(pat, i), gaps);
    send_byte(csum, gaps);
  endtask

  // Called in the CHECK cycle of a good load
  task automatic check_apply(input string tag);
    @(negedge clb_clk);
    total++;
    if (prog_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_check_cycle: actual en=%b busy=%b required en=0 busy=1", tag, prog_en, busy);
    end
    @(negedge clb_clk);
    total++;
    if (prog_en !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency: actual prog_en=%b required=1", tag, prog_en);
    end
    @(negedge clb_clk);
    total++;
    if (prog_en !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || error !== 1'b0 ||
        byte_count !== CW'(NB)) begin
      bad++;
      $display("FAIL %s_status: actual en=%b busy=%b done=%b err=%b cnt=%0d required 0 0 1 0 %0d",
               tag, prog_en, busy, done, error, byte_count, NB);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; cfg_data = 8'h00;
    repeat (2) begin
      @(negedge clb_clk);
      start     = 1'($urandom_range(0, 1));
      cfg_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clb_clk);
    total++;
    if (prog !== '0 || prog_en !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || byte_count !== '0) begin
      bad++;
      $display("FAIL reset_values: actual en=%b rdy=%b busy=%b done=%b err=%b cnt=%0d required all 0",
               prog_en, cfg_ready, busy, done, error, byte_count);
    end
    start = 1'b0; cfg_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clb_clk);
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: actual busy=%b rdy=%b required 0 0", busy, cfg_ready);
    end
  endtask

  task automatic test_good_incr();
    sb.push_back(make_img(0));
    run_load(0, 1'b0, 8'h98);
    check_apply("incr");
    total++;
    if (prog[PW-1:PW-8] !== 8'h00 || prog[15:0] !== 16'h2E2F) begin
      bad++;
      $display("FAIL incr_edges: actual top=%02h low=%04h required 00 2e2f", prog[PW-1:PW-8], prog[15:0]);
    end
  endtask

  task automatic test_gaps();
    int p0 = pulse_cnt;
    sb.push_back(img_a5);
    run_load(1, 1'b1, 8'h10);
    check_apply("gaps");
    total++;
    if (pulse_cnt - p0 != 1) begin
      bad++;
      $display("FAIL gaps_pulses: actual=%0d required=1", pulse_cnt - p0);
    end
  endtask

  task automatic test_bad_csum();
    int p0 = pulse_cnt;
    run_load(1, 1'b0, 8'h11);
    @(negedge clb_clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL bad_check_busy: actual=%b required=1", busy);
    end
    @(negedge clb_clk);
    total++;
    if (busy !== 1'b0 || error !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL bad_status: actual busy=%b err=%b done=%b required 0 1 0", busy, error, done);
    end
    repeat (3) @(negedge clb_clk);
    total++;
    if (pulse_cnt != p0 || prog !== img_a5) begin
      bad++;
      $display("FAIL bad_prog_kept: actual pulses=%0d same_img=%b required 0 1", pulse_cnt - p0, prog === img_a5);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 300; i++) send_byte(pbyte(0, i), 1'b0);
    @(negedge clb_clk);
    cfg_data = 8'h77; cfg_valid = 1'b1; abort = 1'b1;
    @(posedge clb_clk);
    #1;
    cfg_valid = 1'b0; abort = 1'b0;
    @(negedge clb_clk);
    total++;
    if (byte_count !== CW'(300) || busy !== 1'b0 || cfg_ready !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || prog !== img_a5) begin
      bad++;
      $display("FAIL abort_state: actual cnt=%0d busy=%b rdy=%b done=%b err=%b same_img=%b required 300 0 0 0 0 1",
               byte_count, busy, cfg_ready, done, error, prog === img_a5);
    end
    sb.push_back(make_img(0));
    run_load(0, 1'b0, 8'h98);
    check_apply("post_abort");
  endtask

  task automatic test_busy_reset();
    pulse_start();
    for (int i = 0; i < 50; i++) send_byte(pbyte(0, i), 1'b0);
    @(negedge clb_clk);
    cfg_data = 8'h32; cfg_valid = 1'b1; start = 1'b1;
    @(posedge clb_clk);
    #1;
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 51; i < 100; i++) send_byte(pbyte(0, i), 1'b0);
    @(negedge clb_clk);
    total++;
    if (byte_count !== CW'(100) || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_ignored: actual cnt=%0d busy=%b required 100 1", byte_count, busy);
    end
    rst_n = 1'b0;
    @(negedge clb_clk);
    total++;
    if (prog !== '0 || prog_en !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || byte_count !== '0) begin
      bad++;
      $display("FAIL midload_reset: actual prog_zero=%b rdy=%b busy=%b done=%b cnt=%0d required 1 0 0 0 0",
               prog === '0, cfg_ready, busy, done, byte_count);
    end
    rst_n = 1'b1;
    @(negedge clb_clk);
  endtask

  initial begin
    img_a5 = make_img(1);
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; rst_n = 1'b0;
    test_reset();
    test_good_incr();
    test_gaps();
    test_bad_csum();
    test_abort();
    test_busy_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_prog_en: actual pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
